// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode constants, pointer width helper, flag vector layout.
package fifo_pkg;

  // Read modes
  localparam int unsigned FIFO_MODE_STD  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  // Bit positions inside the registered status flag vector
  localparam int unsigned FLAG_FULL   = 0;
  localparam int unsigned FLAG_EMPTY  = 1;
  localparam int unsigned FLAG_AFULL  = 2;
  localparam int unsigned FLAG_AEMPTY = 3;
  localparam int unsigned FLAG_OVF    = 4;
  localparam int unsigned FLAG_UNF    = 5;
  localparam int unsigned NUM_FLAGS   = 6;

  // Pointer width: address bits plus one wrap bit to tell full from empty
  function automatic int unsigned ptr_width(input int unsigned depth);
    return int'($clog2(depth)) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module fifo_mem_dp #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port; contents are intentionally not reset
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_v2.sv
// Synchronous FIFO with occupancy count, almost-full/empty thresholds,
// standard or first-word-fall-through read mode and sticky error flags.
module fifo_sync_v2
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned AF_LVL = 6,
  parameter int unsigned AE_LVL = 2,
  parameter int unsigned FWFT   = 0
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       wr_en_i,
  input  logic                       rd_en_i,
  input  logic                       clr_err_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       almost_full_o,
  output logic                       almost_empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned AW = PW - 1;

  logic [PW-1:0]        wr_ptr_q, rd_ptr_q, count_q;
  logic [PW-1:0]        wr_ptr_n, rd_ptr_n, count_n;
  logic [NUM_FLAGS-1:0] flags_q, flags_n;
  logic                 wr_acc_c, rd_acc_c;
  logic [WIDTH-1:0]     mem_rdata;

  fifo_mem_dp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_acc_c),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (din_i),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  // Accept decisions, next pointers, next occupancy and next flag vector
  always_comb begin
    wr_acc_c = 1'b0;
    rd_acc_c = 1'b0;
    wr_ptr_n = wr_ptr_q;
    rd_ptr_n = rd_ptr_q;
    count_n  = count_q;
    flags_n  = flags_q;

    // Only the registered flags of this cycle decide acceptance
    wr_acc_c = wr_en_i && !flags_q[FLAG_FULL];
    rd_acc_c = rd_en_i && !flags_q[FLAG_EMPTY];

    if (wr_acc_c) wr_ptr_n = wr_ptr_q + PW'(1);
    if (rd_acc_c) rd_ptr_n = rd_ptr_q + PW'(1);
    count_n = wr_ptr_n - rd_ptr_n;

    flags_n[FLAG_FULL]   = (count_n == PW'(DEPTH));
    flags_n[FLAG_EMPTY]  = (count_n == PW'(0));
    flags_n[FLAG_AFULL]  = (count_n >= PW'(AF_LVL));
    flags_n[FLAG_AEMPTY] = (count_n <= PW'(AE_LVL));

    // A fresh error in the same cycle overrides the clear request
    flags_n[FLAG_OVF] = (flags_q[FLAG_OVF] && !clr_err_i) ||
                        (wr_en_i && flags_q[FLAG_FULL]);
    flags_n[FLAG_UNF] = (flags_q[FLAG_UNF] && !clr_err_i) ||
                        (rd_en_i && flags_q[FLAG_EMPTY]);
  end

  // Pointer, count and flag registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q             <= '0;
      rd_ptr_q             <= '0;
      count_q              <= '0;
      flags_q              <= '0;
      flags_q[FLAG_EMPTY]  <= 1'b1;
      flags_q[FLAG_AEMPTY] <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_n;
      rd_ptr_q <= rd_ptr_n;
      count_q  <= count_n;
      flags_q  <= flags_n;
    end
  end

  assign count_o        = count_q;
  assign full_o         = flags_q[FLAG_FULL];
  assign empty_o        = flags_q[FLAG_EMPTY];
  assign almost_full_o  = flags_q[FLAG_AFULL];
  assign almost_empty_o = flags_q[FLAG_AEMPTY];
  assign overflow_o     = flags_q[FLAG_OVF];
  assign underflow_o    = flags_q[FLAG_UNF];

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Head word presented straight from storage; masked to zero while empty
    assign dout_o  = flags_q[FLAG_EMPTY] ? '0 : mem_rdata;
    assign valid_o = !flags_q[FLAG_EMPTY];
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;

    // Registered read data: captured on an accepted read, held otherwise
    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc_c;
        if (rd_acc_c) dout_q <= mem_rdata;
      end
    end

    assign dout_o  = dout_q;
    assign valid_o = valid_q;
  end

endmodule

// File: tb/tb_fifo_sync_v2.sv
// Directed testbench for fifo_sync_v2: one standard-mode and one FWFT instance.
module tb_fifo_sync_v2;

  logic       clk_i = 1'b0;
  logic       reset_ni = 1'b0;

  // Standard-mode instance
  logic [7:0] din = '0;
  logic       wr = 1'b0, rd = 1'b0, clr = 1'b0;
  logic [7:0] dout;
  logic       valid, full, empty, afull, aempty, ovf, unf;
  logic [3:0] count;

  // FWFT instance
  logic [7:0] f_din = '0;
  logic       f_wr = 1'b0, f_rd = 1'b0, f_clr = 1'b0;
  logic [7:0] f_dout;
  logic       f_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
  logic [3:0] f_count;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  fifo_sync_v2 #(.WIDTH(8), .DEPTH(8), .AF_LVL(6), .AE_LVL(2), .FWFT(0)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .din_i(din), .wr_en_i(wr), .rd_en_i(rd),
    .clr_err_i(clr), .dout_o(dout), .valid_o(valid), .full_o(full), .empty_o(empty),
    .almost_full_o(afull), .almost_empty_o(aempty), .count_o(count),
    .overflow_o(ovf), .underflow_o(unf)
  );

  fifo_sync_v2 #(.WIDTH(8), .DEPTH(8), .AF_LVL(6), .AE_LVL(2), .FWFT(1)) dut_fwft (
    .clk_i(clk_i), .reset_ni(reset_ni), .din_i(f_din), .wr_en_i(f_wr), .rd_en_i(f_rd),
    .clr_err_i(f_clr), .dout_o(f_dout), .valid_o(f_valid), .full_o(f_full), .empty_o(f_empty),
    .almost_full_o(f_afull), .almost_empty_o(f_aempty), .count_o(f_count),
    .overflow_o(f_ovf), .underflow_o(f_unf)
  );

  // Advance one rising edge and settle 1 time unit past it
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    step();
    step();
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if ({empty, aempty, full, afull} !== 4'b1100) begin bad++; $display("FAIL reset_flags got=%b exp=1100", {empty, aempty, full, afull}); end
    total++; if ({valid, ovf, unf} !== 3'b000) begin bad++; $display("FAIL reset_vld_err got=%b exp=000", {valid, ovf, unf}); end
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
    total++; if ({f_valid, f_empty} !== 2'b01) begin bad++; $display("FAIL reset_fwft got=%b exp=01", {f_valid, f_empty}); end
    reset_ni = 1'b1;
    step();
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      din = 8'(i); wr = 1'b1;
      step();
      total++; if (count !== 4'(i)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i); end
      total++; if ({full, afull, aempty, empty} !== {i == 8, i >= 6, i <= 2, 1'b0}) begin
        bad++; $display("FAIL fill_flags[%0d] got=%b exp=%b", i, {full, afull, aempty, empty}, {i == 8, i >= 6, i <= 2, 1'b0});
      end
    end
    wr = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      rd = 1'b1;
      step();
      total++; if (dout !== 8'(i) || valid !== 1'b1) begin bad++; $display("FAIL drain_data[%0d] got=%h/%b exp=%h/1", i, dout, valid, 8'(i)); end
      total++; if (count !== 4'(8 - i)) begin bad++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, count, 8 - i); end
    end
    rd = 1'b0;
    step();
    total++; if ({valid, empty, dout} !== {1'b0, 1'b1, 8'h08}) begin bad++; $display("FAIL drain_idle got=%b/%b/%h exp=0/1/08", valid, empty, dout); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) begin din = 8'(8'h10 + i); wr = 1'b1; step(); end
    wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd = 1'b1; step();
      total++; if (dout !== 8'(8'h10 + i)) begin bad++; $display("FAIL wrap_pre[%0d] got=%h exp=%h", i, dout, 8'(8'h10 + i)); end
    end
    rd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      din = 8'(8'hA0 + i); wr = 1'b1; step();
      total++; if (count !== 4'(i + 1) || full !== (i == 7) || empty !== 1'b0) begin
        bad++; $display("FAIL wrap_fill[%0d] got=%0d/%b/%b exp=%0d/%b/0", i, count, full, empty, i + 1, i == 7);
      end
    end
    wr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd = 1'b1; step();
      total++; if (dout !== 8'(8'hA0 + i) || count !== 4'(7 - i) || empty !== (i == 7) || full !== 1'b0) begin
        bad++; $display("FAIL wrap_drain[%0d] got=%h/%0d/%b exp=%h/%0d/%b", i, dout, count, empty, 8'(8'hA0 + i), 7 - i, i == 7);
      end
    end
    rd = 1'b0;
    step();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) begin din = 8'(8'hC0 + i); wr = 1'b1; step(); end
    total++; if (full !== 1'b1 || ovf !== 1'b0) begin bad++; $display("FAIL ovf_full got=%b/%b exp=1/0", full, ovf); end
    din = 8'hFF; wr = 1'b1; rd = 1'b1;
    step();
    total++; if (dout !== 8'hC0 || count !== 4'd7) begin bad++; $display("FAIL ovf_pop got=%h/%0d exp=c0/7", dout, count); end
    total++; if (ovf !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL ovf_flag got=%b/%b exp=1/0", ovf, full); end
    wr = 1'b0; rd = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", ovf); end
    for (int i = 1; i < 8; i++) begin
      rd = 1'b1; step();
      total++; if (dout !== 8'(8'hC0 + i)) begin bad++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, dout, 8'(8'hC0 + i)); end
    end
    rd = 1'b0;
    step();
    total++; if (empty !== 1'b1 || count !== 4'd0) begin bad++; $display("FAIL ovf_empty got=%b/%0d exp=1/0", empty, count); end
  endtask

  task automatic test_underflow();
    rd = 1'b1;
    step();
    total++; if ({unf, valid} !== 2'b10 || count !== 4'd0) begin bad++; $display("FAIL unf_set got=%b/%b/%0d exp=1/0/0", unf, valid, count); end
    din = 8'h5A; wr = 1'b1; rd = 1'b1;
    step();
    wr = 1'b0;
    total++; if (count !== 4'd1 || valid !== 1'b0 || empty !== 1'b0 || unf !== 1'b1) begin
      bad++; $display("FAIL unf_rdwr got=%0d/%b/%b/%b exp=1/0/0/1", count, valid, empty, unf);
    end
    rd = 1'b1; clr = 1'b1;
    step();
    total++; if (dout !== 8'h5A || valid !== 1'b1 || count !== 4'd0) begin bad++; $display("FAIL unf_read got=%h/%b/%0d exp=5a/1/0", dout, valid, count); end
    total++; if (unf !== 1'b0) begin bad++; $display("FAIL unf_clr got=%b exp=0", unf); end
    step();
    total++; if (unf !== 1'b1) begin bad++; $display("FAIL unf_err_wins got=%b exp=1", unf); end
    rd = 1'b0;
    step();
    clr = 1'b0;
    total++; if (unf !== 1'b0) begin bad++; $display("FAIL unf_clr2 got=%b exp=0", unf); end
  endtask

  task automatic test_fwft();
    f_din = 8'h33; f_wr = 1'b1;
    step();
    f_wr = 1'b0;
    total++; if (f_dout !== 8'h33 || f_valid !== 1'b1 || f_empty !== 1'b0) begin
      bad++; $display("FAIL fwft_show got=%h/%b/%b exp=33/1/0", f_dout, f_valid, f_empty);
    end
    step();
    total++; if (f_dout !== 8'h33 || f_valid !== 1'b1) begin bad++; $display("FAIL fwft_hold got=%h/%b exp=33/1", f_dout, f_valid); end
    f_rd = 1'b1;
    step();
    f_rd = 1'b0;
    total++; if (f_valid !== 1'b0 || f_empty !== 1'b1 || f_count !== 4'd0) begin
      bad++; $display("FAIL fwft_pop got=%b/%b/%0d exp=0/1/0", f_valid, f_empty, f_count);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin din = 8'(8'h70 + i); wr = 1'b1; step(); end
    wr = 1'b0; rd = 1'b1;
    step();
    rd = 1'b0;
    total++; if (count !== 4'd4 || valid !== 1'b1 || dout !== 8'h70) begin bad++; $display("FAIL rstm_pre got=%0d/%b/%h exp=4/1/70", count, valid, dout); end
    #2 reset_ni = 1'b0;
    #1;
    total++; if (count !== 4'd0 || {empty, aempty, full, afull} !== 4'b1100) begin
      bad++; $display("FAIL rstm_async got=%0d/%b exp=0/1100", count, {empty, aempty, full, afull});
    end
    total++; if ({valid, ovf, unf} !== 3'b000 || dout !== 8'h00) begin bad++; $display("FAIL rstm_out got=%b/%h exp=000/00", {valid, ovf, unf}, dout); end
    step();
    #2 reset_ni = 1'b1;
    din = 8'h11; wr = 1'b1;
    step();
    wr = 1'b0; rd = 1'b1;
    step();
    rd = 1'b0;
    total++; if (dout !== 8'h11 || valid !== 1'b1 || count !== 4'd0) begin bad++; $display("FAIL rstm_after got=%h/%b/%0d exp=11/1/0", dout, valid, count); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_overflow();
    test_underflow();
    test_fwft();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
